// File: rtl/btn_pulse_pkg.sv
// Shared types and default timing constants for the push-button front end.
package btn_pulse_pkg;

  typedef enum logic [0:0] {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } btn_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_CNT_W           = 20;
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, STABLE/CHECK debounce FSM, registered pulses.
// Auto-repeat of the press pulse is built only when AUTO_REPEAT_EN is defined.
module btn_debounce_ch
  import btn_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic busy
);

  if (DEBOUNCE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_debounce_cfg
    $error("btn_debounce_ch: need DEBOUNCE_CYCLES >= 2 and 2**CNT_W > DEBOUNCE_CYCLES");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat_cfg
    $error("btn_debounce_ch: REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             s_q;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d;
  logic             press_d;
  logic             release_d;
  logic             rpt_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      s_q           <= 1'b0;
      state_q       <= STABLE;
      cnt_q         <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1_q       <= raw;
      s_q           <= sync1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      level         <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    level_d   = level;
    press_d   = rpt_fire;
    release_d = 1'b0;
    case (state_q)
      STABLE: begin
        if (s_q != level) begin
          state_d = CHECK;
          cnt_d   = CNT_W'(1);
        end
      end
      CHECK: begin
        if (s_q == level) begin
          state_d = STABLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = STABLE;
          level_d   = s_q;
          press_d   = s_q;
          release_d = ~s_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = STABLE;
    endcase
  end

  assign busy = (state_q == CHECK);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_q;
  logic             rpt_periodic_q;
  logic             rpt_run;

  // Runs only while held high and undisturbed; any candidate change (entering CHECK) clears it.
  assign rpt_run  = (state_q == STABLE) && level && s_q;
  assign rpt_fire = rpt_run && (rpt_q == (rpt_periodic_q ? RPT_PERIOD_LAST : RPT_DELAY_LAST));

  always_ff @(posedge clk) begin
    if (reset || !rpt_run) begin
      rpt_q          <= '0;
      rpt_periodic_q <= 1'b0;
    end else if (rpt_fire) begin
      rpt_q          <= '0;
      rpt_periodic_q <= 1'b1;
    end else begin
      rpt_q <= rpt_q + RPT_W'(1);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/button_pulse_gen.sv
// Push-button front end: N_BTN independent debounced channels with press/release pulses.
// Optional auto-repeat press pulses are enabled by defining AUTO_REPEAT_EN.
module button_pulse_gen
  import btn_pulse_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_busy
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .raw          (btn_raw[i]),
      .level        (btn_level[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i]),
      .busy         (btn_busy[i])
    );
  end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Self-checking bench for button_pulse_gen with a run-length reference model of the debounce rules.
module tb_button_pulse_gen;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int CW = 3;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [N-1:0] m_sy1, m_sy2, m_lvl, m_press, m_rel, m_busy;
  int         m_run  [N];
  int         m_hold [N];

  button_pulse_gen #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_busy   (btn_busy)
  );

  always #5 clk = ~clk;

  // Level flips once D consecutive synchronised samples disagree with it.
  task automatic model_edge();
    bit s;
    bit prev_lvl;
    int prev_run;
    for (int c = 0; c < N; c++) begin
      if (reset) begin
        m_sy1[c] = 0; m_sy2[c] = 0; m_lvl[c] = 0; m_press[c] = 0;
        m_rel[c] = 0; m_busy[c] = 0; m_run[c] = 0; m_hold[c] = 0;
      end else begin
        s        = m_sy2[c];
        prev_lvl = m_lvl[c];
        prev_run = m_run[c];
        m_press[c] = 0;
        m_rel[c]   = 0;
        if (s != m_lvl[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == D) begin
            m_lvl[c]   = s;
            m_run[c]   = 0;
            m_press[c] = s;
            m_rel[c]   = !s;
          end
        end else begin
          m_run[c] = 0;
        end
        if (AUTO && prev_lvl && prev_run == 0 && s) begin
          m_hold[c] = m_hold[c] + 1;
          if (m_hold[c] >= RD && (m_hold[c] - RD) % RP == 0) m_press[c] = 1;
        end else begin
          m_hold[c] = 0;
        end
        m_sy2[c]  = m_sy1[c];
        m_sy1[c]  = btn_raw[c];
        m_busy[c] = (m_run[c] != 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    btn_raw = 4'hF;
    repeat (3) begin
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_busy} !== 16'h0) begin
        errors++;
        $display("FAIL reset_outputs: got %h want 0000", {btn_level, btn_press, btn_release, btn_busy});
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (btn_level !== ((k == 6) ? 4'hF : 4'h0) || btn_press !== ((k == 6) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL reset_release_latency k=%0d: level=%h press=%h want %h", k, btn_level, btn_press,
                 (k == 6) ? 4'hF : 4'h0);
      end
    end
  endtask

  task automatic test_clean_press();
    btn_raw = 4'h0;
    repeat (8) begin
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_busy} !== {m_lvl, m_press, m_rel, m_busy}) begin
        errors++;
        $display("FAIL settle_low: got %h want %h", {btn_level, btn_press, btn_release, btn_busy},
                 {m_lvl, m_press, m_rel, m_busy});
      end
    end
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (btn_press[0] !== (k == 6) || btn_level[0] !== (k >= 6) || btn_release[0] !== 1'b0) begin
        errors++;
        $display("FAIL clean_press k=%0d: press=%b level=%b rel=%b want press=%b level=%b rel=0",
                 k, btn_press[0], btn_level[0], btn_release[0], k == 6, k >= 6);
      end
    end
  endtask

  task automatic test_bounce();
    bit busy_seen = 0;
    for (int k = 0; k < 12; k++) begin
      btn_raw[1] = (k < 4) && (k % 2 == 0);
      tick();
      busy_seen |= btn_busy[1];
      checks++;
      if (btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0 || btn_busy !== m_busy) begin
        errors++;
        $display("FAIL bounce k=%0d: level1=%b press1=%b busy=%h want 0 0 %h",
                 k, btn_level[1], btn_press[1], btn_busy, m_busy);
      end
    end
    checks++;
    if (busy_seen !== 1'b1) begin
      errors++;
      $display("FAIL bounce_busy: seen=%b want 1", busy_seen);
    end
  endtask

  task automatic test_hold_release();
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (btn_release[0] !== (k == 6) || btn_level[0] !== (k < 6) || (k == 6 && btn_press[0] !== 1'b0)) begin
        errors++;
        $display("FAIL hold_release k=%0d: rel=%b level=%b press=%b want rel=%b level=%b",
                 k, btn_release[0], btn_level[0], btn_press[0], k == 6, k < 6);
      end
    end
  endtask

  task automatic test_reset_mid_check();
    btn_raw[3] = 1'b1;
    repeat (4) tick();
    checks++;
    if (btn_busy[3] !== 1'b1 || btn_level[3] !== 1'b0) begin
      errors++;
      $display("FAIL mid_check_busy: busy3=%b level3=%b want 1 0", btn_busy[3], btn_level[3]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({btn_level, btn_press, btn_release, btn_busy} !== 16'h0) begin
      errors++;
      $display("FAIL mid_check_reset: got %h want 0000", {btn_level, btn_press, btn_release, btn_busy});
    end
    btn_raw = 4'h0;
    repeat (8) begin
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_busy} !== {m_lvl, m_press, m_rel, m_busy}) begin
        errors++;
        $display("FAIL after_mid_reset: got %h want %h", {btn_level, btn_press, btn_release, btn_busy},
                 {m_lvl, m_press, m_rel, m_busy});
      end
    end
  endtask

  task automatic test_auto_repeat();
    int got[$];
    int want[$];
    want.push_back(6);
    if (AUTO) begin
      want.push_back(16); want.push_back(19); want.push_back(22);
      want.push_back(25); want.push_back(28);
    end
    btn_raw[2] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (btn_press[2]) got.push_back(k);
      checks++;
      if ({btn_level, btn_press, btn_release, btn_busy} !== {m_lvl, m_press, m_rel, m_busy}) begin
        errors++;
        $display("FAIL repeat_model k=%0d: got %h want %h", k, {btn_level, btn_press, btn_release, btn_busy},
                 {m_lvl, m_press, m_rel, m_busy});
      end
    end
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL repeat_times: got %p want %p", got, want);
    end
    btn_raw = 4'h0;
    repeat (10) tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 5) == 0) btn_raw[c] = ~btn_raw[c];
      reset = ($urandom_range(0, 149) == 0);
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_busy} !== {m_lvl, m_press, m_rel, m_busy}) begin
        errors++;
        $display("FAIL random k=%0d: got %h want %h", k, {btn_level, btn_press, btn_release, btn_busy},
                 {m_lvl, m_press, m_rel, m_busy});
      end
      checks++;
      if ((btn_press & btn_release) !== 4'h0) begin
        errors++;
        $display("FAIL press_release_overlap k=%0d: got %h want 0", k, btn_press & btn_release);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_release();
    test_reset_mid_check();
    test_auto_repeat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
